// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: program counter, IF/ID pipeline register and consecutive-stall watchdog.
// Optional total-stall counter on Stall_Count is enabled by defining STALL_COUNT_EN.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
    parameter int          STALL_LIMIT = 16
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Stall_PC,
    input  logic        Stall_ID,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic [31:0] Instruction_In,
    output logic [31:0] PC_Out,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic        Stall_Timeout,
    output logic [31:0] Stall_Count
);

    localparam int              RUN_W   = $clog2(STALL_LIMIT) + 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifidInstr_q, ifidInstr_d;
    logic [31:0]      ifidPc4_q, ifidPc4_d;
    logic             ifidValid_q, ifidValid_d;
    logic [RUN_W-1:0] runCnt_q, runCnt_d;
    logic             timeout_q, timeout_d;
    logic             stall;
    logic [31:0]      pcPlus4;
    logic             unusedTargetBits;

    // A mismatched stall pair is treated as a full stall so nothing is dropped or duplicated.
    assign stall            = Stall_PC | Stall_ID;
    assign pcPlus4          = pc_q + 32'd4;
    assign unusedTargetBits = ^Branch_Target[1:0];

    always_comb begin
        pc_d        = pc_q;
        ifidInstr_d = ifidInstr_q;
        ifidPc4_d   = ifidPc4_q;
        ifidValid_d = ifidValid_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (Branch_Taken) begin
            pc_d        = {Branch_Target[31:2], 2'b00};
            ifidInstr_d = NOP_WORD;
            ifidPc4_d   = 32'd0;
            ifidValid_d = 1'b0;
        end else begin
            pc_d        = pcPlus4;
            ifidInstr_d = Instruction_In;
            ifidPc4_d   = pcPlus4;
            ifidValid_d = 1'b1;
        end
    end

    // Run counter saturates at the limit; the timeout flag is sticky until reset.
    always_comb begin
        runCnt_d  = '0;
        timeout_d = timeout_q;
        if (stall) begin
            runCnt_d = (runCnt_q == RUN_MAX) ? runCnt_q : runCnt_q + 1'b1;
        end
        if (runCnt_d == RUN_MAX) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            pc_q        <= RESET_PC;
            ifidInstr_q <= NOP_WORD;
            ifidPc4_q   <= 32'd0;
            ifidValid_q <= 1'b0;
            runCnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ifidInstr_q <= ifidInstr_d;
            ifidPc4_q   <= ifidPc4_d;
            ifidValid_q <= ifidValid_d;
            runCnt_q    <= runCnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef STALL_COUNT_EN
    logic [31:0] stallCount_q;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            stallCount_q <= 32'd0;
        end else if (stall) begin
            stallCount_q <= stallCount_q + 32'd1;
        end
    end

    assign Stall_Count = stallCount_q;
`else
    assign Stall_Count = 32'd0;
`endif

    assign PC_Out           = pc_q;
    assign IFID_Instruction = ifidInstr_q;
    assign IFID_PCPlus4     = ifidPc4_q;
    assign IFID_Valid       = ifidValid_q;
    assign Stall_Timeout    = timeout_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed bench for fetch_stage_ctrl: a reference model pushes expected state into a
// scoreboard queue as each cycle is driven, and the entry is popped and checked after the edge.
module tb_fetch_stage_ctrl;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int          STALL_LIMIT = 16;

    logic        Clock;
    logic        Reset_n;
    logic        Stall_PC;
    logic        Stall_ID;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic [31:0] Instruction_In;
    logic [31:0] PC_Out;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        Stall_Timeout;
    logic [31:0] Stall_Count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        timeout;
        logic [31:0] count;
    } exp_t;

    exp_t sbQ[$];

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mPc, mInstr, mPc4, mCount;
    logic        mValid, mTimeout;
    int          mRun;

    fetch_stage_ctrl #(
        .RESET_PC   (RESET_PC),
        .NOP_WORD   (NOP_WORD),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .Stall_PC        (Stall_PC),
        .Stall_ID        (Stall_ID),
        .Branch_Taken    (Branch_Taken),
        .Branch_Target   (Branch_Target),
        .Instruction_In  (Instruction_In),
        .PC_Out          (PC_Out),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4    (IFID_PCPlus4),
        .IFID_Valid      (IFID_Valid),
        .Stall_Timeout   (Stall_Timeout),
        .Stall_Count     (Stall_Count)
    );

    // Instruction memory returns its own address as the word.
    assign Instruction_In = PC_Out;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        vectors++;
        assert (sbQ.size() != 0) else begin
            miscompares++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkValue("PC_Out", PC_Out, e.pc);
            checkValue("IFID_Instruction", IFID_Instruction, e.instr);
            checkValue("IFID_PCPlus4", IFID_PCPlus4, e.pc4);
            checkValue("IFID_Valid", {31'd0, IFID_Valid}, {31'd0, e.valid});
            checkValue("Stall_Timeout", {31'd0, Stall_Timeout}, {31'd0, e.timeout});
            checkValue("Stall_Count", Stall_Count, e.count);
        end
    endtask

    task automatic applyStimulus(input logic rstn, input logic sp, input logic si,
                                 input logic br, input logic [31:0] tgt);
        exp_t e;
        Reset_n       = rstn;
        Stall_PC      = sp;
        Stall_ID      = si;
        Branch_Taken  = br;
        Branch_Target = tgt;
        if (!rstn) begin
            mPc = RESET_PC; mInstr = NOP_WORD; mPc4 = 32'd0;
            mValid = 1'b0; mTimeout = 1'b0; mRun = 0; mCount = 32'd0;
        end else if (sp || si) begin
            mRun = (mRun == STALL_LIMIT) ? mRun : mRun + 1;
            if (mRun == STALL_LIMIT) mTimeout = 1'b1;
`ifdef STALL_COUNT_EN
            mCount = mCount + 32'd1;
`endif
        end else begin
            mRun = 0;
            if (br) begin
                mPc = {tgt[31:2], 2'b00}; mInstr = NOP_WORD; mPc4 = 32'd0; mValid = 1'b0;
            end else begin
                mInstr = mPc; mPc4 = mPc + 32'd4; mPc = mPc + 32'd4; mValid = 1'b1;
            end
        end
        e.pc = mPc; e.instr = mInstr; e.pc4 = mPc4;
        e.valid = mValid; e.timeout = mTimeout; e.count = mCount;
        sbQ.push_back(e);
        @(posedge Clock);
        #1;
        checkOutput();
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic stallFor(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0; Stall_PC = 1'b0; Stall_ID = 1'b0;
        Branch_Taken = 1'b0; Branch_Target = 32'd0;
        mPc = RESET_PC; mInstr = NOP_WORD; mPc4 = 32'd0;
        mValid = 1'b0; mTimeout = 1'b0; mRun = 0; mCount = 32'd0;
        #2;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkValue("reset_pc", PC_Out, 32'h0);
        checkValue("reset_valid", {31'd0, IFID_Valid}, 32'd0);

        advance(1);
        checkValue("first_pc", PC_Out, 32'h4);
        checkValue("first_instr", IFID_Instruction, 32'h0);
        checkValue("first_valid", {31'd0, IFID_Valid}, 32'd1);
        advance(1);
        checkValue("second_instr", IFID_Instruction, 32'h4);
        checkValue("second_pc4", IFID_PCPlus4, 32'h8);
        advance(2);
        checkValue("pre_stall_pc", PC_Out, 32'h10);

        stallFor(3);
        checkValue("stall_pc", PC_Out, 32'h10);
        checkValue("stall_instr", IFID_Instruction, 32'hC);
        advance(1);
        checkValue("post_stall_pc", PC_Out, 32'h14);

        advance(3);
        checkValue("pre_branch_pc", PC_Out, 32'h20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        checkValue("branch_pc", PC_Out, 32'h40);
        checkValue("branch_instr", IFID_Instruction, NOP_WORD);
        advance(1);
        checkValue("target_instr", IFID_Instruction, 32'h40);
        checkValue("target_pc4", IFID_PCPlus4, 32'h44);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h80);
        checkValue("half_stall_pc", PC_Out, 32'h44);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h43);
        checkValue("align_pc", PC_Out, 32'h40);
        advance(1);

        stallFor(15);
        advance(1);
        stallFor(15);
        advance(1);
        checkValue("no_timeout", {31'd0, Stall_Timeout}, 32'd0);
        stallFor(16);
        checkValue("timeout_set", {31'd0, Stall_Timeout}, 32'd1);
        advance(2);
        checkValue("timeout_sticky", {31'd0, Stall_Timeout}, 32'd1);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checkValue("top_pc", PC_Out, 32'hFFFF_FFFC);
        advance(1);
        checkValue("wrap_pc", PC_Out, 32'h0);
        checkValue("wrap_pc4", IFID_PCPlus4, 32'h0);
        advance(2);

        stallFor(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        checkValue("mid_reset_pc", PC_Out, RESET_PC);
        checkValue("mid_reset_valid", {31'd0, IFID_Valid}, 32'd0);
        checkValue("mid_reset_timeout", {31'd0, Stall_Timeout}, 32'd0);
        advance(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
